hilo_muldiv_ctrl: RTL and testbench
===================================

# hilo_muldiv_ctrl

Sequencer for the HI/LO register pair and the multiply/divide datapath behind mult/multu/div/divu, mfhi/mflo and mthi/mtlo. It sits in the execute stage beside the ALU. It accepts one operation from the decode/execute path and runs an iterative 32-step divide, and an iterative or single-cycle multiply. It raises a stall to the pipeline while a dependent HI/LO access or a new operation arrives before the result is ready.

## Interface
- Parameters: none. Width fixed at 32.
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  issue request, valid while decode flags mult/div class
- op  in  2  00 mult, 01 multu, 10 div, 11 divu
- a  in  32  rs operand, dividend or multiplicand
- b  in  32  rt operand, divisor or multiplier
- mthi, mtlo  in  1 each  write wdata to HI or LO
- wdata  in  32  rs value for mthi/mtlo
- mfhi, mflo  in  1 each  pipeline wants to read HI or LO this cycle
- cancel  in  1  exception/eret flush; abort in-flight operation
- hi, lo  out  32 each  current HI/LO register contents
- busy  out  1  operation in flight (state != IDLE)
- stall  out  1  hold pipeline
- div_zero  out  1  one-cycle pulse when a divide with b==0 was accepted

## Operation
- States: IDLE, PREP, ITER, FIX.
- IDLE: start accepted only here. Priority: start > mthi/mtlo. mthi and mtlo in the same cycle write both registers.
- PREP: latch |a| and |b| (signed ops) or raw values (unsigned ops). Latch result sign = a[31]^b[31]. Latch remainder sign = a[31] (div). Clear the 5-bit step counter.
- ITER: one shift-subtract (div, restoring) or shift-add (mult) step per cycle for 32 cycles. The counter is 0..31; leave ITER when the counter reaches 31.
- FIX: apply sign correction with two's-complement negation of the 64-bit product or of the quotient and remainder separately. Write HI/LO, then return to IDLE.
- Results:
  - mult: {HI,LO} = a*b (64-bit).
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - 0x80000000 / -1: LO=0x80000000, HI=0. Needs no special case.
- Divide by zero: bypass PREP/ITER and go IDLE→FIX for one cycle. Result is LO=0xFFFFFFFF, HI=a, and div_zero pulses in the accept cycle.
- stall = busy & (start | mfhi | mflo | mthi | mtlo). Requests made while busy are ignored, not queued; the pipeline holds them asserted until stall drops.
- cancel:
  - In any state: go to IDLE next cycle, HI/LO unchanged.
  - Together with start in IDLE: start ignored.
  - In FIX: the write is suppressed.
- reset: state IDLE; hi=0, lo=0, busy=0, stall=0, div_zero=0; counter and internal operands cleared.

## Timing
- Start sampled at edge E0. Iterative ops:
  - PREP during cycle 1.
  - ITER during cycles 2–33.
  - FIX during cycle 34.
  - HI/LO are updated at the edge ending cycle 34.
  - busy=0 and the new value is visible on hi/lo in cycle 35, giving 34 busy cycles.
- Divide by zero: FIX during cycle 1, result visible in cycle 2, 1 busy cycle.
- mthi/mtlo in IDLE: write at the next edge, visible the following cycle.
- hi/lo are direct register outputs; no bypass from FIX.
- stall is combinational from busy and the request inputs.

## Configuration
- HILO_FAST_MUL_EN defined:
  - mult/multu compute a*b with a single-cycle multiplier.
  - HI/LO are written at the accepting edge E0.
  - busy never asserts for multiply.
  - Divide is unchanged.
- HILO_FAST_MUL_EN undefined: multiply uses the 34-cycle PREP/ITER/FIX path above.

## Structure
- Shared package hilo_pkg holds:
  - op encodings MULDIV_MULT/MULTU/DIV/DIVU
  - the state enum
  - ITER_STEPS=32
  - the DIVZ_LO constant 0xFFFFFFFF
- Sub-module muldiv_step: combinational single step. Inputs are 64-bit accumulator, 32-bit operand and mode. Outputs are the next accumulator, for either shift-subtract or shift-add. The top level holds the FSM, counter, sign flags and HI/LO registers.

## Test plan
- divu a=100, b=7 → busy high exactly 34 cycles; then LO=14, HI=2.
- div a=0xFFFFFFF9 (-7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Also div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- mult a=0xFFFFFFFD (-3), b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu same operands → HI=0x00000004, LO=0xFFFFFFF1. Check latency 1 and 34 cycles with and without HILO_FAST_MUL_EN.
- divu a=0x1234, b=0 → div_zero pulse; one cycle later LO=0xFFFFFFFF, HI=0x1234.
- Stall and ignore while busy:
  - mthi wdata=0xAAAA0000, then divu 9/4.
  - mflo held from cycle 3 → stall=1 until busy falls; then lo=2, hi=1.
  - mtlo asserted while busy → ignored; lo=2, not wdata.
- Cancel and reset:
  - div in flight, cancel at ITER step 10 → IDLE next cycle, HI/LO keep prior values.
  - reset asserted mid-ITER → all outputs 0 at the next edge.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// operation encodings, FSM states, step modes and fixed constants.
package hilo_pkg;

  localparam int          ITER_STEPS = 32;
  localparam logic [31:0] DIVZ_LO    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MULDIV_MULT  = 2'b00,
    MULDIV_MULTU = 2'b01,
    MULDIV_DIV   = 2'b10,
    MULDIV_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    ITER = 2'b10,
    FIX  = 2'b11
  } state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  // Magnitude of a 32-bit value when treated as signed; passthrough otherwise.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_if.sv
// Execute-stage bundle between the pipeline (master) and the HI/LO
// multiply/divide sequencer (slave).
interface hilo_muldiv_ctrl_if;

  logic                 start;
  hilo_pkg::muldiv_op_t op;
  logic [31:0]          a;
  logic [31:0]          b;
  logic                 mthi;
  logic                 mtlo;
  logic [31:0]          wdata;
  logic                 mfhi;
  logic                 mflo;
  logic                 cancel;
  logic [31:0]          hi;
  logic [31:0]          lo;
  logic                 busy;
  logic                 stall;
  logic                 div_zero;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata, mfhi, mflo, cancel,
    input  hi, lo, busy, stall, div_zero
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata, mfhi, mflo, cancel,
    output hi, lo, busy, stall, div_zero
  );

endinterface

// File: rtl/muldiv_step.sv
// One iteration of the datapath: restoring shift-subtract for divide
// ({rem, quot} accumulator) or shift-add for multiply ({hi, multiplier}).
module muldiv_step
  import hilo_pkg::*;
(
  input  logic [63:0] i_acc,
  input  logic [31:0] i_opnd,
  input  step_mode_t  i_mode,
  output logic [63:0] o_acc
);

  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [32:0] w_sum;

  // Next accumulator for the selected step kind.
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every path, else a latch is inferred.
    o_acc    = i_acc;
    w_rem_sh = i_acc[63:31];
    w_ge     = (w_rem_sh >= {1'b0, i_opnd});
    // The partial remainder minus divisor is below 2^32 whenever w_ge, so modular 32-bit subtract is exact.
    w_sub    = w_rem_sh[31:0] - i_opnd;
    w_sum    = {1'b0, i_acc[63:32]} + {1'b0, i_opnd};
    if (i_mode == STEP_DIV) begin
      if (w_ge) o_acc = {w_sub, i_acc[30:0], 1'b1};
      else      o_acc = {w_rem_sh[31:0], i_acc[30:0], 1'b0};
    end else begin
      if (i_acc[0]) o_acc = {w_sum, i_acc[31:1]};
      else          o_acc = {1'b0, i_acc[63:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO register pair and mult/div sequencer (IDLE -> PREP -> ITER x32 -> FIX).
// Optional: HILO_FAST_MUL_EN selects a single-cycle multiplier written at the
// accepting edge; divide always uses the iterative path.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  hilo_muldiv_ctrl_if.slave   io
);

  localparam logic [4:0] LAST_STEP = 5'(ITER_STEPS - 1);

  state_t      r_state;
  logic [4:0]  r_cnt;
  muldiv_op_t  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_opnd;
  logic [63:0] r_acc;
  logic        r_sign_res;
  logic        r_sign_rem;
  logic        r_divz;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_div_zero;

  logic        w_in_div;
  logic        w_r_signed;
  logic        w_r_div;
  logic [63:0] w_step_acc;
  logic [63:0] w_prod;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_in_div   = io.op[1];
  assign w_r_div    = r_op[1];
  assign w_r_signed = ~r_op[0];

  muldiv_step u_step (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_mode (w_r_div ? STEP_DIV : STEP_MUL),
    .o_acc  (w_step_acc)
  );

`ifdef HILO_FAST_MUL_EN
  logic [63:0] w_fast_prod;
  logic        w_in_signed;
  assign w_in_signed = ~io.op[0];
  // Sign- or zero-extended 64-bit operands give the correct low 64 product bits for both forms.
  assign w_fast_prod = {{32{w_in_signed & io.a[31]}}, io.a} * {{32{w_in_signed & io.b[31]}}, io.b};
`endif

  // Sign correction and result selection applied in FIX.
  always_comb begin
    w_prod   = r_sign_res ? (~r_acc + 64'd1) : r_acc;
    w_fix_hi = w_prod[63:32];
    w_fix_lo = w_prod[31:0];
    if (r_divz) begin
      w_fix_hi = r_a;
      w_fix_lo = DIVZ_LO;
    end else if (w_r_div) begin
      w_fix_lo = r_sign_res ? (~r_acc[31:0] + 32'd1)  : r_acc[31:0];
      w_fix_hi = r_sign_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end
  end

  // Sequencer FSM with registered HI/LO, busy and div_zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: datapath registers are reset too, so no stale operand survives into the next operation.
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_op       <= MULDIV_MULT;
      r_a        <= '0;
      r_b        <= '0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_sign_res <= 1'b0;
      r_sign_rem <= 1'b0;
      r_divz     <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_div_zero <= 1'b0;
      if (io.cancel) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (io.start) begin
              r_op <= io.op;
              r_a  <= io.a;
              r_b  <= io.b;
              if (w_in_div && (io.b == 32'd0)) begin
                r_divz     <= 1'b1;
                r_div_zero <= 1'b1;
                r_state    <= FIX;
                r_busy     <= 1'b1;
              end
`ifdef HILO_FAST_MUL_EN
              else if (!w_in_div) begin
                r_hi <= w_fast_prod[63:32];
                r_lo <= w_fast_prod[31:0];
              end
`endif
              else begin
                r_divz  <= 1'b0;
                r_state <= PREP;
                r_busy  <= 1'b1;
              end
            end else begin
              if (io.mthi) r_hi <= io.wdata;
              if (io.mtlo) r_lo <= io.wdata;
            end
          end
          PREP: begin
            r_acc      <= {32'd0, w_r_div ? abs32(r_a, w_r_signed) : abs32(r_b, w_r_signed)};
            r_opnd     <= w_r_div ? abs32(r_b, w_r_signed) : abs32(r_a, w_r_signed);
            r_sign_res <= w_r_signed & (r_a[31] ^ r_b[31]);
            r_sign_rem <= w_r_signed & r_a[31];
            r_cnt      <= '0;
            r_state    <= ITER;
          end
          ITER: begin
            r_acc <= w_step_acc;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == LAST_STEP) r_state <= FIX;
          end
          FIX: begin
            r_hi    <= w_fix_hi;
            r_lo    <= w_fix_lo;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io.hi       = r_hi;
  assign io.lo       = r_lo;
  assign io.busy     = r_busy;
  assign io.div_zero = r_div_zero;
  assign io.stall    = r_busy & (io.start | io.mfhi | io.mflo | io.mthi | io.mtlo);

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl with a result scoreboard.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

`ifdef HILO_FAST_MUL_EN
  localparam int MUL_CYC = 0;
`else
  localparam int MUL_CYC = 34;
`endif
  localparam int DIV_CYC = 34;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       tag;
  } exp_t;

  logic clock;
  logic reset;
  int   n_vec;
  int   n_err;
  exp_t sb[$];

  hilo_muldiv_ctrl_if io ();

  hilo_muldiv_ctrl dut (
    .clock (clock),
    .reset (reset),
    .io    (io)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation; optionally record its expected result.
  task automatic launch(input muldiv_op_t op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                        input logic track, input logic [31:0] eh, input logic [31:0] el,
                        input int cyc, input logic dz, input string tag);
    exp_t e;
    if (track) begin
      e.hi = eh; e.lo = el; e.cyc = cyc; e.tag = tag;
      sb.push_back(e);
    end
    io.op    = op_i;
    io.a     = a_i;
    io.b     = b_i;
    io.start = 1'b1;
    @(negedge clock);
    io.start = 1'b0;
    check({tag, "/div_zero"}, 32'(io.div_zero), 32'(dz));
  endtask

  // Pop the oldest expectation and compare latency and HI/LO.
  task automatic finish_op(input int cnt);
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "/cycles"}, 32'(cnt), 32'(e.cyc));
      check({e.tag, "/hi"}, io.hi, e.hi);
      check({e.tag, "/lo"}, io.lo, e.lo);
    end
  endtask

  // Count busy cycles (already in cycle 1) with a bound, then score.
  task automatic drain();
    int cnt = 0;
    while (io.busy === 1'b1 && cnt < 200) begin
      cnt++;
      @(negedge clock);
    end
    finish_op(cnt);
  endtask

  initial begin
    int k;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    io.start = 1'b0; io.op = MULDIV_MULT; io.a = '0; io.b = '0;
    io.mthi = 1'b0; io.mtlo = 1'b0; io.wdata = '0;
    io.mfhi = 1'b0; io.mflo = 1'b0; io.cancel = 1'b0;
    repeat (3) @(negedge clock);
    check("rst/hi", io.hi, 32'd0);
    check("rst/lo", io.lo, 32'd0);
    check("rst/busy", 32'(io.busy), 32'd0);
    check("rst/stall", 32'(io.stall), 32'd0);
    check("rst/div_zero", 32'(io.div_zero), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    launch(MULDIV_DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, DIV_CYC, 1'b0, "divu_100_7");
    drain();
    launch(MULDIV_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC, 1'b0, "div_m7_2");
    drain();
    launch(MULDIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, DIV_CYC, 1'b0, "div_min_m1");
    drain();
    launch(MULDIV_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_CYC, 1'b0, "mult_m3_5");
    drain();
    launch(MULDIV_MULTU, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'h0000_0004, 32'hFFFF_FFF1, MUL_CYC, 1'b0, "multu_m3_5");
    drain();
    launch(MULDIV_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b1, 32'h0000_000F, 32'h0FFF_FFFF, DIV_CYC, 1'b0, "divu_max_16");
    drain();
    launch(MULDIV_DIVU, 32'h1234, 32'd0, 1'b1, 32'h1234, DIVZ_LO, 1, 1'b1, "divu_by_zero");
    drain();
    check("divz/pulse_gone", 32'(io.div_zero), 32'd0);

    // Stall and ignore while busy.
    io.mthi = 1'b1; io.wdata = 32'hAAAA_0000;
    @(negedge clock);
    io.mthi = 1'b0;
    check("mthi/hi", io.hi, 32'hAAAA_0000);
    launch(MULDIV_DIVU, 32'd9, 32'd4, 1'b1, 32'd1, 32'd2, DIV_CYC, 1'b0, "divu_9_4_stall");
    @(negedge clock);
    @(negedge clock);
    io.mflo = 1'b1;
    #1;
    k = 2;
    while (io.busy === 1'b1 && k < 200) begin
      check("busy/stall", 32'(io.stall), 32'd1);
      if (k == 4) begin io.mtlo = 1'b1; io.wdata = 32'h5555_5555; end
      if (k == 9) io.mtlo = 1'b0;
      k++;
      @(negedge clock);
    end
    check("idle/stall", 32'(io.stall), 32'd0);
    finish_op(k);
    io.mflo = 1'b0;

    // Cancel during ITER step 10: HI/LO keep 1/2.
    launch(MULDIV_DIV, 32'd1000, 32'd3, 1'b0, '0, '0, 0, 1'b0, "div_cancel");
    repeat (11) @(negedge clock);
    check("cancel/busy_before", 32'(io.busy), 32'd1);
    io.cancel = 1'b1;
    @(negedge clock);
    io.cancel = 1'b0;
    check("cancel/busy", 32'(io.busy), 32'd0);
    repeat (3) @(negedge clock);
    check("cancel/hi", io.hi, 32'd1);
    check("cancel/lo", io.lo, 32'd2);

    // Cancel together with start in IDLE: start is dropped.
    io.op = MULDIV_DIVU; io.a = 32'd50; io.b = 32'd5;
    io.start = 1'b1; io.cancel = 1'b1;
    @(negedge clock);
    io.start = 1'b0; io.cancel = 1'b0;
    check("start_cancel/busy", 32'(io.busy), 32'd0);

    // mthi and mtlo in the same cycle write both.
    io.mthi = 1'b1; io.mtlo = 1'b1; io.wdata = 32'h1357_9BDF;
    @(negedge clock);
    io.mthi = 1'b0; io.mtlo = 1'b0;
    check("mthilo/hi", io.hi, 32'h1357_9BDF);
    check("mthilo/lo", io.lo, 32'h1357_9BDF);

    // Reset mid-ITER clears everything.
    launch(MULDIV_DIVU, 32'd77, 32'd5, 1'b0, '0, '0, 0, 1'b0, "divu_reset");
    repeat (8) @(negedge clock);
    io.mflo = 1'b1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst/hi", io.hi, 32'd0);
    check("mid_rst/lo", io.lo, 32'd0);
    check("mid_rst/busy", 32'(io.busy), 32'd0);
    check("mid_rst/stall", 32'(io.stall), 32'd0);
    check("mid_rst/div_zero", 32'(io.div_zero), 32'd0);
    reset = 1'b0;
    io.mflo = 1'b0;
    @(negedge clock);

    launch(MULDIV_MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'd0, MUL_CYC, 1'b0, "mult_min_min");
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
